// File: rtl/apb3_pkg.sv
// Shared definitions for the APB3 master: FSM state encoding and default
// width / timeout constants.
package apb3_pkg;

    localparam int DEF_ADDR_WIDTH     = 16;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Wide enough for the largest legal TIMEOUT_CYCLES (65535).
    localparam int TIMEOUT_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage : apb3_pkg

// File: rtl/apb3_master_timeout.sv
// ACCESS-phase wait counter for the APB3 master; only instantiated when
// APB3_MASTER_TIMEOUT_EN is defined.
module apb3_master_timeout
    import apb3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_CNT_WIDTH-1:0] LAST_WAIT =
        TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_CNT_WIDTH-1:0] count;

    // Flags the stalled cycle whose increment would make the count reach
    // TIMEOUT_CYCLES, so the abort lands on exactly that ACCESS cycle.
    assign expired = enable && (count == LAST_WAIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TIMEOUT_CNT_WIDTH'(1);
        end
    end

endmodule : apb3_master_timeout

// File: rtl/apb3_master.sv
// APB3 initiator bridging a valid/ready request/response interface onto APB3.
// Define APB3_MASTER_TIMEOUT_EN to compile in the ACCESS-phase timeout.
module apb3_master
    import apb3_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,

    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERROR
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb3_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    apb_state_e state;
    apb_state_e state_next;
    logic       out_of_reset;
    logic       accept;
    logic       complete;
    logic       timeout_hit;

`ifdef APB3_MASTER_TIMEOUT_EN
    logic timeout_q;

    apb3_master_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (state == SETUP),
        .enable  ((state == ACCESS) && !PREADY),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout_q <= 1'b0;
        end else if (complete) begin
            timeout_q <= !PREADY;
        end
    end

    assign rsp_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign accept   = req_valid && req_ready;
    assign complete = (state == ACCESS) && (PREADY || timeout_hit);

    // Keeps req_ready low during reset and until the first edge after release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = out_of_reset;
                if (req_valid && out_of_reset) state_next = SETUP;
            end
            SETUP: begin
                PSEL       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || timeout_hit) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset as well, because every output
    // must read 0 while resetn is low, not just the control signals.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (accept) begin
            PADDR  <= req_addr;
            PWRITE <= req_write;
            PWDATA <= req_wdata;
        end
    end

    // A timeout completes with PREADY low; read data is only kept for clean reads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (complete) begin
            rsp_rdata <= (!PREADY || PWRITE || PSLVERROR) ? '0 : PRDATA;
            rsp_error <= !PREADY || PSLVERROR;
        end
    end

endmodule : apb3_master

// File: doc/apb3_master.md
APB3_MASTER -- requirements
Module: apb3_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-phase wait cycles (range 1..65535).
REQ-004 SHALL use one clock and an asynchronous, active-low reset; the ports are listed below.
REQ-005 clk  in  1  system clock; all logic on the rising edge.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  request pending.
REQ-008 req_ready  out  1  request accepted when high together with req_valid.
REQ-009 req_write  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_WIDTH  transfer address.
REQ-011 req_wdata  in  DATA_WIDTH  write data.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts.
REQ-015 rsp_error  out  1  slave error or timeout.
REQ-016 rsp_timeout  out  1  transfer aborted by timeout.
REQ-017 PADDR  out  ADDR_WIDTH; PSEL  out  1; PENABLE  out  1; PWRITE  out  1; PWDATA  out  DATA_WIDTH  APB3 initiator signals.
REQ-018 PREADY  in  1; PRDATA  in  DATA_WIDTH; PSLVERROR  in  1  APB3 completer signals.

Function
REQ-019 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP.
REQ-020 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-021 IDLE -> SETUP SHALL occur when req_valid && req_ready, latching write, addr and wdata on that edge.
REQ-022 SETUP SHALL last exactly one cycle, with PSEL=1 and PENABLE=0, and SHALL then go to ACCESS.
REQ-023 ACCESS SHALL drive PSEL=1 and PENABLE=1, and SHALL remain in ACCESS while PREADY=0.
REQ-024 ACCESS with PREADY=1 SHALL go to RESP, capturing PRDATA (reads only) and PSLVERROR into rsp_rdata and rsp_error.
REQ-025 PADDR, PWRITE and PWDATA SHALL hold the latched values, unchanged, from SETUP through the end of ACCESS.
REQ-026 PSEL and PENABLE SHALL be 0 in IDLE and RESP.
REQ-027 RESP SHALL hold rsp_valid=1, with the response stable, until rsp_ready=1; it SHALL then go to IDLE and clear rsp_valid.
REQ-028 Minimum transfer latency SHALL be 3 cycles from acceptance to rsp_valid (PREADY high in the first ACCESS cycle).
REQ-029 Minimum request spacing SHALL be 4 cycles (accept, SETUP, ACCESS, RESP with rsp_ready=1).
REQ-030 req_valid dropping while not accepted SHALL have no effect.
REQ-031 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-032 While resetn=0, the state SHALL be IDLE and all outputs SHALL be 0, including req_ready.
REQ-033 req_ready SHALL rise on the first clock edge after resetn deasserts.
REQ-034 Reset asserted mid-transfer SHALL drop PSEL/PENABLE immediately and discard the pending transfer and response.

Configuration
REQ-035 The macro APB3_MASTER_TIMEOUT_EN SHALL, when defined, compile in a counter that is cleared on SETUP and increments each ACCESS cycle with PREADY=0.
REQ-036 With APB3_MASTER_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES, the FSM SHALL go to RESP with rsp_error=1, rsp_timeout=1 and rsp_rdata=0.
REQ-037 With APB3_MASTER_TIMEOUT_EN defined, PREADY=1 on the same cycle the count reaches TIMEOUT_CYCLES SHALL complete the transfer normally, with no timeout.
REQ-038 Without APB3_MASTER_TIMEOUT_EN, ACCESS SHALL wait indefinitely and rsp_timeout SHALL be tied to 0; the port list SHALL be identical in both builds.

Structure
REQ-039 The shared package apb3_pkg SHALL hold the FSM state encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3) and the default width/timeout constants.
REQ-040 The timeout counter SHALL be the sub-module apb3_master_timeout (inputs clear, enable; output expired), instantiated only under APB3_MASTER_TIMEOUT_EN.

Verification
REQ-041 Write addr=0x0010, wdata=0xDEADBEEF, PREADY=1 immediately -> PSEL is high for cycles 1-2 after accept, PENABLE for cycle 2, rsp_valid in cycle 3, rsp_error=0, rsp_rdata=0.
REQ-042 Read addr=0x0004, slave holds PREADY=0 for 5 ACCESS cycles then PRDATA=0x12345678 -> PADDR stays stable throughout, rsp_rdata=0x12345678.
REQ-043 Read with PSLVERROR=1 at PREADY -> rsp_error=1, rsp_timeout=0, rsp_rdata=0.
REQ-044 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and data stay stable, req_ready=0, and a new req_valid is not accepted.
REQ-045 With APB3_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, PREADY stuck at 0 -> abort after 8 ACCESS cycles, rsp_timeout=1, PSEL=0 in RESP; a second run with PREADY=1 on the 8th cycle -> normal completion.
REQ-046 Assert resetn=0 during ACCESS -> PSEL, PENABLE and rsp_valid are 0 asynchronously; after release, req_ready=1 and the next write completes normally.
